// File: rtl/mtr_pkg.sv
// mtr_pkg: shared constants and types for the motor-drive PWM stage.
//   PWM_W          period counter / duty width
//   PWM_MID        duty at zero speed (50 %)
//   DEADTIME_DEF   default non-overlap interval in clocks
//   SLEW_STEP_DEF  default per-period duty step (MTR_SLEW_EN builds only)
//   duty_t         duty / counter type
package mtr_pkg;

  localparam int PWM_W         = 11;
  localparam logic [10:0] PWM_MID = 11'h400;
  localparam int DEADTIME_DEF  = 32;
  localparam int SLEW_STEP_DEF = 64;

  typedef logic [PWM_W-1:0] duty_t;

  // Signed speed plus 0x400 is the speed with its MSB inverted.
  function automatic duty_t spd2duty(input logic [PWM_W-1:0] spd);
    return spd ^ PWM_MID;
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_nonoverlap.sv
// nonoverlap: dead-time generator for one H-bridge wheel.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   raw_i    raw PWM (registered compare result)
//   pwm1_o   high-side drive, raw high and dead time elapsed
//   pwm2_o   low-side drive, raw low and dead time elapsed
// Any raw edge restarts the dead counter; both legs stay low until it
// saturates at DEADTIME, so the legs can never be driven together.
module nonoverlap
  import mtr_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pwm1_o,
  output logic pwm2_o
);

  localparam logic [7:0] DT = 8'(DEADTIME);

  logic [7:0] dead_q, dead_d;
  logic       raw_q;
  logic       done_d;
  logic       pwm1_q, pwm2_q;

  always_comb begin
    dead_d = dead_q;
    if (raw_i != raw_q)
      dead_d = '0;
    else if (dead_q != DT)
      dead_d = dead_q + 8'd1;
    done_d = (dead_d == DT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dead_q <= '0;
      raw_q  <= 1'b0;
      pwm1_q <= 1'b0;
      pwm2_q <= 1'b0;
    end else begin
      dead_q <= dead_d;
      raw_q  <= raw_i;
      pwm1_q <= raw_i & done_d;
      pwm2_q <= ~raw_i & done_d;
    end
  end

  assign pwm1_o = pwm1_q;
  assign pwm2_o = pwm2_q;

endmodule

// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: converts signed 11-bit wheel speed commands into
// complementary dead-timed H-bridge PWM pairs with a 2048-clock period.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   lft_spd   signed left speed command
//   rght_spd  signed right speed command
//   lftPWM1/lftPWM2    left high/low-side drives
//   rghtPWM1/rghtPWM2  right high/low-side drives
//   prd_strt  one-clock pulse while the period counter is 0
// Optional feature: define MTR_SLEW_EN to limit duty change per period
// to SLEW_STEP; otherwise the duty loads the target directly.
module mtr_drv_pwm
  import mtr_pkg::*;
#(
  parameter int DEADTIME  = DEADTIME_DEF,
  parameter int SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PWM_W-1:0]  lft_spd,
  input  logic [PWM_W-1:0]  rght_spd,
  output logic              lftPWM1,
  output logic              lftPWM2,
  output logic              rghtPWM1,
  output logic              rghtPWM2,
  output logic              prd_strt
);

  duty_t cnt_q, cnt_d;
  duty_t lft_duty_q, lft_duty_d;
  duty_t rght_duty_q, rght_duty_d;
  logic  lft_raw_q, rght_raw_q;
  logic  prd_q;

`ifdef MTR_SLEW_EN
  function automatic duty_t next_duty(input duty_t cur, input duty_t tgt);
    logic [11:0] c, t, s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = 12'(SLEW_STEP);
    if (t > c + s)
      return duty_t'(c + s);
    else if (c > t + s)
      return duty_t'(c - s);
    else
      return tgt;
  endfunction
`else
  function automatic duty_t next_duty(input duty_t cur, input duty_t tgt);
    duty_t unused_cur;
    unused_cur = cur;
    return tgt | (unused_cur & '0);
  endfunction
`endif

  always_comb begin
    cnt_d       = cnt_q + 11'd1;
    lft_duty_d  = lft_duty_q;
    rght_duty_d = rght_duty_q;
    // Load on the last clock so the new duty applies from cnt == 0.
    if (cnt_q == '1) begin
      lft_duty_d  = next_duty(lft_duty_q, spd2duty(lft_spd));
      rght_duty_d = next_duty(rght_duty_q, spd2duty(rght_spd));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      lft_duty_q  <= PWM_MID;
      rght_duty_q <= PWM_MID;
      lft_raw_q   <= 1'b0;
      rght_raw_q  <= 1'b0;
      prd_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lft_duty_q  <= lft_duty_d;
      rght_duty_q <= rght_duty_d;
      lft_raw_q   <= (cnt_q < lft_duty_q);
      rght_raw_q  <= (cnt_q < rght_duty_q);
      // Registered from the wrap condition so it is high exactly while
      // cnt == 0, yet stays low during and straight after reset.
      prd_q       <= (cnt_q == '1);
    end
  end

  assign prd_strt = prd_q;

  nonoverlap #(.DEADTIME(DEADTIME)) u_lft (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (lft_raw_q),
    .pwm1_o (lftPWM1),
    .pwm2_o (lftPWM2)
  );

  nonoverlap #(.DEADTIME(DEADTIME)) u_rght (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (rght_raw_q),
    .pwm1_o (rghtPWM1),
    .pwm2_o (rghtPWM2)
  );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Self-checking bench for mtr_drv_pwm. A period-level model predicts
// per-period pulse counts from each period's duty; prd_strt and the
// non-overlap invariant are checked every cycle.
module tb_mtr_drv_pwm;

  localparam int DT   = 32;
  localparam int STEP = 64;
  localparam int PER  = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] lft_spd = '0;
  logic [10:0] rght_spd = '0;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;

  int total = 0;
  int bad   = 0;

  int k;                          // clocks since reset release
  int dl, dr;                     // model duty of current period
  int wl, wl_prev, wr, wr_prev;   // duty of window being counted and its predecessor
  int cl1, cl2, cr1, cr2;
  int last_l1, last_l2, last_r1, last_r2;

  always #5 clk = ~clk;

  mtr_drv_pwm #(.DEADTIME(DT), .SLEW_STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2),
    .prd_strt (prd_strt)
  );

  function automatic int next_duty(int cur, logic [10:0] spd);
    int tgt;
    tgt = int'($signed(spd)) + 1024;
`ifdef MTR_SLEW_EN
    if (tgt > cur + STEP) return cur + STEP;
    if (tgt < cur - STEP) return cur - STEP;
`endif
    return tgt;
  endfunction

  function automatic int max0(int v);
    return (v > 0) ? v : 0;
  endfunction

  function automatic int exp_hi(int d);
    return max0(d - DT);
  endfunction

  // Low-side count; at duty 0 the low run started in the previous period.
  function automatic int exp_lo(int d, int dp);
    if (d > 0)   return max0(PER - d - DT);
    if (dp == 0) return PER;
    return PER - max0(DT - (PER - dp));
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_l1"}, 32'(lftPWM1), 0);
    check({tag, "_l2"}, 32'(lftPWM2), 0);
    check({tag, "_r1"}, 32'(rghtPWM1), 0);
    check({tag, "_r2"}, 32'(rghtPWM2), 0);
    check({tag, "_prd"}, 32'(prd_strt), 0);
  endtask

  task automatic model_reset();
    k = 0; dl = 1024; dr = 1024;
    wl = 1024; wl_prev = 1024; wr = 1024; wr_prev = 1024;
    cl1 = 0; cl2 = 0; cr1 = 0; cr2 = 0;
  endtask

  task automatic finalize();
    last_l1 = cl1; last_l2 = cl2; last_r1 = cr1; last_r2 = cr2;
    check("lft_pwm1_cnt",  32'(cl1), 32'(exp_hi(wl)));
    check("lft_pwm2_cnt",  32'(cl2), 32'(exp_lo(wl, wl_prev)));
    check("rght_pwm1_cnt", 32'(cr1), 32'(exp_hi(wr)));
    check("rght_pwm2_cnt", 32'(cr2), 32'(exp_lo(wr, wr_prev)));
  endtask

  // One clock: model advance at posedge, sample at negedge.
  task automatic cyc();
    @(posedge clk);
    k++;
    if (k % PER == 0) begin
      dl = next_duty(dl, lft_spd);
      dr = next_duty(dr, rght_spd);
    end
    @(negedge clk);
    check("prd_strt", 32'(prd_strt), (k % PER == 0) ? 1 : 0);
    check("ovl_lft",  32'(lftPWM1 & lftPWM2), 0);
    check("ovl_rght", 32'(rghtPWM1 & rghtPWM2), 0);
    // Outputs lag the compare by 2 clocks, so windows start at cnt == 2.
    if (k >= 2 && (k - 2) % PER == 0) begin
      if (k >= PER + 2) finalize();
      wl_prev = wl; wl = dl;
      wr_prev = wr; wr = dr;
      cl1 = 0; cl2 = 0; cr1 = 0; cr2 = 0;
    end
    cl1 += int'(lftPWM1);
    cl2 += int'(lftPWM2);
    cr1 += int'(rghtPWM1);
    cr2 += int'(rghtPWM2);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  // Called at a negedge: drop reset between edges and check outputs at once.
  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1 check_zero("rst_init");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold0");
    end
    rst_n = 1'b1;
    model_reset();

    // Zero speed: 50 % duty on both wheels.
    run(PER + 2);
    check("zero_l1", 32'(last_l1), 992);
    check("zero_l2", 32'(last_l2), 992);
    check("zero_r1", 32'(last_r1), 992);
    check("zero_r2", 32'(last_r2), 992);
    run(PER);

    // Full forward on the left wheel.
    lft_spd = 11'h3FF;
    run(2 * PER);
`ifndef MTR_SLEW_EN
    check("fwd_l1", 32'(last_l1), 2015);
    check("fwd_l2", 32'(last_l2), 0);
    check("fwd_r1", 32'(last_r1), 992);
    check("fwd_r2", 32'(last_r2), 992);
`endif

    // Full reverse on the right wheel.
    rght_spd = 11'h400;
    run(2 * PER);
`ifndef MTR_SLEW_EN
    check("rev_r1", 32'(last_r1), 0);
    check("rev_r2", 32'(last_r2), 2048);
`endif

    // Mid-period command change only takes effect next period.
    lft_spd = 11'h000;
    run(PER + 'h200 - 2);
    lft_spd = 11'h100;
    run(PER - 'h200 + 2);
`ifndef MTR_SLEW_EN
    check("mid_keep_l1", 32'(last_l1), 992);
`endif
    run(PER);
`ifndef MTR_SLEW_EN
    check("mid_next_l1", 32'(last_l1), 1248);
`endif

    // Random speeds, one asynchronous reset mid-period.
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, PER - 1);
      run(n);
      lft_spd  = 11'($urandom);
      rght_spd = 11'($urandom);
      if (p == 10) pulse_reset();
      run(PER - n);
    end
    run(PER + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
